// File: rtl/fog_adc_demod.sv
// FOG detector demodulator: keeps the last ADC sample of each modulation half,
// integrates (pos - neg) and (pos + neg) over 2^ACC_LOG2 periods, and emits a
// saturated signed error word plus the mean detector level.
// Optional build macro DEMOD_SIGN_INV_EN inverts the error sign (neg - pos).
module fog_adc_demod #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ACC_LOG2 = 9,
  parameter int unsigned ERR_W    = 16
) (
  input  logic                     Refin_Clk,
  input  logic                     SYS_RST,
  input  logic                     SYS_START,
  input  logic [DATA_W-1:0]        AD_DATA,
  input  logic                     AD_VALID,
  input  logic                     Phase_Pos,
  input  logic                     Period_Start,
  output logic signed [ERR_W-1:0]  Err,
  output logic                     Err_Valid,
  output logic [DATA_W-1:0]        Mean,
  output logic                     Sync_Err
);

  localparam int unsigned DW = DATA_W + ACC_LOG2 + 2;  // difference accumulator
  localparam int unsigned SW = DATA_W + ACC_LOG2 + 1;  // sum accumulator
  localparam int unsigned QW = DATA_W + 2;             // acc_d after >>> ACC_LOG2

  localparam logic signed [QW-1:0] ErrMax = {{(QW-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
  localparam logic signed [QW-1:0] ErrMin = {{(QW-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StSync, StAccum} state_t;

  state_t                    state_q;
  logic                      phase_q;
  logic [DATA_W-1:0]         pos_smp_q, neg_smp_q;
  logic                      pos_seen_q, neg_seen_q, fell_q;
  logic signed [DW-1:0]      acc_d_q;
  logic [SW-1:0]             acc_s_q;
  logic [ACC_LOG2-1:0]       cnt_q;
  logic signed [QW-1:0]      snap_d_q;
  logic [DATA_W-1:0]         snap_s_q;
  logic                      dump_q;

  logic                      fall;
  logic signed [DW-1:0]      acc_d_fall, acc_d_close;
  logic [SW-1:0]             acc_s_close;
  logic signed [QW-1:0]      err_src;
  logic signed [ERR_W-1:0]   err_sat;

  // Half-closing arithmetic and error saturation.
  always_comb begin
    fall        = phase_q & ~Phase_Pos;
    acc_d_fall  = acc_d_q + $signed({{(DW-DATA_W){1'b0}}, pos_smp_q});
    acc_d_close = acc_d_q - $signed({{(DW-DATA_W){1'b0}}, neg_smp_q});
    acc_s_close = acc_s_q + {{(SW-DATA_W){1'b0}}, pos_smp_q}
                          + {{(SW-DATA_W){1'b0}}, neg_smp_q};
`ifdef DEMOD_SIGN_INV_EN
    err_src     = -snap_d_q;
`else
    err_src     = snap_d_q;
`endif
    err_sat     = err_src[ERR_W-1:0];
    if (err_src > ErrMax) begin
      err_sat = ErrMax[ERR_W-1:0];
    end else if (err_src < ErrMin) begin
      err_sat = ErrMin[ERR_W-1:0];
    end
  end

  // Control FSM, sample latches, accumulators and registered outputs.
  always_ff @(posedge Refin_Clk or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q    <= StIdle;
      phase_q    <= 1'b0;
      pos_smp_q  <= '0;
      neg_smp_q  <= '0;
      pos_seen_q <= 1'b0;
      neg_seen_q <= 1'b0;
      fell_q     <= 1'b0;
      acc_d_q    <= '0;
      acc_s_q    <= '0;
      cnt_q      <= '0;
      snap_d_q   <= '0;
      snap_s_q   <= '0;
      dump_q     <= 1'b0;
      Err        <= '0;
      Err_Valid  <= 1'b0;
      Mean       <= {1'b0, {(DATA_W-1){1'b1}}};
      Sync_Err   <= 1'b0;
    end else begin
      phase_q   <= Phase_Pos;
      Err_Valid <= 1'b0;
      dump_q    <= 1'b0;
      if (!SYS_START) begin
        // Abort: drop everything in flight, keep the last published Err/Mean.
        state_q    <= StIdle;
        pos_smp_q  <= '0;
        neg_smp_q  <= '0;
        pos_seen_q <= 1'b0;
        neg_seen_q <= 1'b0;
        fell_q     <= 1'b0;
        acc_d_q    <= '0;
        acc_s_q    <= '0;
        cnt_q      <= '0;
      end else begin
        if (dump_q) begin
          Err       <= err_sat;
          Mean      <= snap_s_q;
          Err_Valid <= 1'b1;
        end
        unique case (state_q)
          StIdle: state_q <= StSync;
          StSync: begin
            if (Period_Start) begin
              state_q    <= StAccum;
              acc_d_q    <= '0;
              acc_s_q    <= '0;
              cnt_q      <= '0;
              fell_q     <= 1'b0;
              neg_seen_q <= 1'b0;
              pos_seen_q <= AD_VALID;
              if (AD_VALID) pos_smp_q <= AD_DATA;
            end
          end
          StAccum: begin
            if (fall) begin
              if (!pos_seen_q) begin
                Sync_Err   <= 1'b1;
                state_q    <= StSync;
                acc_d_q    <= '0;
                acc_s_q    <= '0;
                cnt_q      <= '0;
                pos_seen_q <= 1'b0;
                neg_seen_q <= 1'b0;
                fell_q     <= 1'b0;
              end else begin
                acc_d_q <= acc_d_fall;
                fell_q  <= 1'b1;
                // A sample on the falling cycle already belongs to the negative half.
                if (AD_VALID) begin
                  neg_smp_q  <= AD_DATA;
                  neg_seen_q <= 1'b1;
                end
              end
            end else if (Period_Start) begin
              if (!fell_q || !neg_seen_q) begin
                // The closing Period_Start does not open a new period.
                Sync_Err   <= 1'b1;
                state_q    <= StSync;
                acc_d_q    <= '0;
                acc_s_q    <= '0;
                cnt_q      <= '0;
                pos_seen_q <= 1'b0;
                neg_seen_q <= 1'b0;
                fell_q     <= 1'b0;
              end else begin
                if (&cnt_q) begin
                  snap_d_q <= acc_d_close[DW-1:ACC_LOG2];
                  snap_s_q <= acc_s_close[SW-1:ACC_LOG2+1];
                  dump_q   <= 1'b1;
                  acc_d_q  <= '0;
                  acc_s_q  <= '0;
                  cnt_q    <= '0;
                end else begin
                  acc_d_q  <= acc_d_close;
                  acc_s_q  <= acc_s_close;
                  cnt_q    <= cnt_q + ACC_LOG2'(1);
                end
                fell_q     <= 1'b0;
                neg_seen_q <= 1'b0;
                pos_seen_q <= AD_VALID;
                if (AD_VALID) pos_smp_q <= AD_DATA;
              end
            end else if (AD_VALID) begin
              if (Phase_Pos) begin
                pos_smp_q  <= AD_DATA;
                pos_seen_q <= 1'b1;
              end else begin
                neg_smp_q  <= AD_DATA;
                neg_seen_q <= 1'b1;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fog_adc_demod.sv
// Scoreboard bench for fog_adc_demod with ACC_LOG2=2 (4 periods per word).
module tb_fog_adc_demod;

  logic               Refin_Clk = 1'b0;
  logic               SYS_RST, SYS_START, AD_VALID, Phase_Pos, Period_Start;
  logic [15:0]        AD_DATA;
  logic signed [15:0] Err;
  logic               Err_Valid;
  logic [15:0]        Mean;
  logic               Sync_Err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] err;
    logic [15:0] mean;
  } exp_t;
  exp_t sb[$];

  fog_adc_demod #(
    .DATA_W   (16),
    .ACC_LOG2 (2),
    .ERR_W    (16)
  ) dut (
    .Refin_Clk    (Refin_Clk),
    .SYS_RST      (SYS_RST),
    .SYS_START    (SYS_START),
    .AD_DATA      (AD_DATA),
    .AD_VALID     (AD_VALID),
    .Phase_Pos    (Phase_Pos),
    .Period_Start (Period_Start),
    .Err          (Err),
    .Err_Valid    (Err_Valid),
    .Mean         (Mean),
    .Sync_Err     (Sync_Err)
  );

  always #5 Refin_Clk = ~Refin_Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected Err from the hand-computed average (pos - neg) per period.
  function automatic logic [15:0] exp_err(input int avg);
    int v;
    logic [31:0] t;
`ifdef DEMOD_SIGN_INV_EN
    v = -avg;
`else
    v = avg;
`endif
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    t = v;
    return t[15:0];
  endfunction

  // Monitor: every Err_Valid pulse must match the oldest expected word.
  always @(negedge Refin_Clk) begin
    if (Err_Valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_err_valid actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("err", Err, e.err);
        chk("mean", Mean, e.mean);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  // Hold the given inputs for one clock cycle.
  task automatic step(input bit ps, input bit ph, input bit av, input logic [15:0] d);
    Period_Start = ps;
    Phase_Pos    = ph;
    AD_VALID     = av;
    AD_DATA      = d;
    @(posedge Refin_Clk);
    #1;
  endtask

  task automatic pstart();
    step(1'b1, 1'b1, 1'b0, 16'h0000);
  endtask

  // One period body after its Period_Start: np positive samples, optional negative sample.
  task automatic body(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                      input int np, input logic [15:0] n, input bit nv);
    if (np > 0) step(1'b0, 1'b1, 1'b1, p0);
    if (np > 1) step(1'b0, 1'b1, 1'b1, p1);
    if (np > 2) step(1'b0, 1'b1, 1'b1, p2);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    if (nv) step(1'b0, 1'b0, 1'b1, n);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  // Closing Period_Start of a block; Err_Valid must rise exactly two cycles later.
  task automatic close_blk(input int avg, input logic [15:0] mean);
    exp_t e;
    e.err  = exp_err(avg);
    e.mean = mean;
    sb.push_back(e);
    pstart();
    Period_Start = 1'b0;
    @(negedge Refin_Clk);
    chk("lat_n1", {15'b0, Err_Valid}, 16'h0000);
    @(posedge Refin_Clk);
    #1;
    @(negedge Refin_Clk);
    chk("lat_n2", {15'b0, Err_Valid}, 16'h0001);
    @(posedge Refin_Clk);
    #1;
  endtask

  // Four periods (first already opened by a Period_Start) and the closing edge.
  task automatic four(input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                      input int np, input logic [15:0] n, input int avg,
                      input logic [15:0] mean);
    body(p0, p1, p2, np, n, 1'b1);
    repeat (3) begin
      pstart();
      body(p0, p1, p2, np, n, 1'b1);
    end
    close_blk(avg, mean);
  endtask

  initial begin
    SYS_RST = 1'b1;
    SYS_START = 1'b0;
    AD_VALID = 1'b0;
    Phase_Pos = 1'b0;
    Period_Start = 1'b0;
    AD_DATA = '0;
    repeat (3) @(posedge Refin_Clk);
    #1;
    chk("rst_err", Err, 16'h0000);
    chk("rst_mean", Mean, 16'h7FFF);
    chk("rst_err_valid", {15'b0, Err_Valid}, 16'h0000);
    chk("rst_sync_err", {15'b0, Sync_Err}, 16'h0000);
    SYS_RST = 1'b0;
    SYS_START = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    pstart();

    // Basic, saturating (both signs) and last-sample-wins blocks.
    four(16'h9000, 16'h9000, 16'h9000, 1, 16'h7000, 8192, 16'h8000);
    four(16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 65535, 16'h7FFF);
    four(16'h0000, 16'h0000, 16'h0000, 1, 16'hFFFF, -65535, 16'h7FFF);
    four(16'h1000, 16'h2000, 16'h9000, 3, 16'h7000, 8192, 16'h8000);

    // Missing negative sample in period 2, then resync.
    body(16'hA000, 16'hA000, 16'hA000, 1, 16'h6000, 1'b1);
    pstart();
    body(16'hA000, 16'hA000, 16'hA000, 1, 16'h6000, 1'b0);
    pstart();
    chk("sync_err_set", {15'b0, Sync_Err}, 16'h0001);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    pstart();
    four(16'hA000, 16'hA000, 16'hA000, 1, 16'h6000, 16384, 16'h8000);
    chk("sync_err_sticky", {15'b0, Sync_Err}, 16'h0001);

    // Reset in period 3 of a block.
    body(16'h8800, 16'h8800, 16'h8800, 1, 16'h7800, 1'b1);
    pstart();
    body(16'h8800, 16'h8800, 16'h8800, 1, 16'h7800, 1'b1);
    pstart();
    step(1'b0, 1'b1, 1'b1, 16'h8800);
    SYS_RST = 1'b1;
    #1;
    chk("mid_rst_err", Err, 16'h0000);
    chk("mid_rst_mean", Mean, 16'h7FFF);
    chk("mid_rst_sync_err", {15'b0, Sync_Err}, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    SYS_RST = 1'b0;
    // Activity without Period_Start must not accumulate while in SYNC.
    body(16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 1'b1);
    pstart();
    four(16'h8800, 16'h8800, 16'h8800, 1, 16'h7800, 4096, 16'h8000);

    // One-cycle SYS_START drop in period 2.
    body(16'h7000, 16'h7000, 16'h7000, 1, 16'h9000, 1'b1);
    pstart();
    step(1'b0, 1'b1, 1'b1, 16'h7000);
    SYS_START = 1'b0;
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    SYS_START = 1'b1;
    chk("drop_err_hold", Err, exp_err(4096));
    chk("drop_mean_hold", Mean, 16'h8000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 16'h9000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    pstart();
    four(16'h7000, 16'h7000, 16'h7000, 1, 16'h9000, -8192, 16'h8000);

    repeat (4) step(1'b0, 1'b1, 1'b0, 16'h0000);
    chk("sb_empty", 16'(sb.size()), 16'h0000);
    chk("sync_err_final", {15'b0, Sync_Err}, 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fog_adc_demod.md
Name: fog_adc_demod

Overview:
- Receive-side counterpart of the LTC1668 square-wave modulation driver in the FOG loop.
- Takes detector ADC samples, aligns them to the modulation half-periods flagged by the driver, and integrates (positive half − negative half) over 2^ACC_LOG2 periods.
- Emits a signed demodulated error word plus a mean level for the feedback/step-wave logic.

Parameters:
- DATA_W, 16, ADC sample width (unsigned offset-binary, 0x7FFF = 0 V).
- ACC_LOG2, 9, log2 of modulation periods per output word (default 512).
- ERR_W, 16, signed error output width; Err saturates to this width.

Ports:
- Refin_Clk  in  1  system clock; all logic on rising edge.
- SYS_RST  in  1  asynchronous active-high reset.
- SYS_START  in  1  run enable; low = synchronous return to IDLE.
- AD_DATA  in  DATA_W  ADC sample, valid only with AD_VALID.
- AD_VALID  in  1  one-cycle strobe per converted sample.
- Phase_Pos  in  1  high during positive modulation half, low during negative half.
- Period_Start  in  1  one-cycle pulse at the start of each positive half; coincides with the cycle Phase_Pos goes high.
- Err  out  ERR_W  signed demodulated error.
- Err_Valid  out  1  one-cycle pulse when Err/Mean update.
- Mean  out  DATA_W  average detector level.
- Sync_Err  out  1  sticky flag: a half-period closed with no valid sample.

Behaviour:
- Reset (async, SYS_RST=1): state IDLE; Err=0, Mean=0x7FFF, Err_Valid=0, Sync_Err=0; accumulators, period counter, and sample latches all cleared.
- States:
  - IDLE → SYNC when SYS_START=1.
  - SYNC → ACCUM on the first Period_Start.
  - ACCUM: any state → IDLE on SYS_START=0 (synchronous); this clears accumulators, counter, latches, and any pending dump; Err/Mean hold; Err_Valid forced to 0.
- Sample selection:
  - Each half keeps only its LAST AD_VALID sample (settled value); a "seen" flag is set per half.
  - AD_VALID coincident with a half-closing event belongs to the NEW half.
- Positive half closes on Phase_Pos falling: accumulator acc_d += pos_sample (zero-extended).
- Negative half closes on Period_Start: acc_d −= neg_sample, acc_s += pos_sample + neg_sample, period counter +1.
- Missing sample: a half closing with "seen"=0 sets Sync_Err (sticky until reset), discards the current 2^ACC_LOG2 block (accumulators and counter cleared), and returns to SYNC. The Period_Start that closes the bad half does not itself start a new period.
- Accumulator widths:
  - acc_d: signed DATA_W+ACC_LOG2+2 bits.
  - acc_s: unsigned DATA_W+ACC_LOG2+1 bits.
  - No internal overflow is possible.
- Dump:
  - On the Period_Start that completes period 2^ACC_LOG2, the final values are copied to snapshot registers. In the same cycle the accumulators restart at zero and the counter restarts at 0, with no gap; the next positive half accumulates normally.
  - Cycle N+1: Err = acc_d >>> ACC_LOG2 (arithmetic), saturated to [−2^(ERR_W−1), 2^(ERR_W−1)−1]; Mean = acc_s >> (ACC_LOG2+1).
  - Both are registered; Err_Valid=1 at cycle N+2 for exactly one cycle.
  - Latency: closing Period_Start to Err_Valid = 2 cycles.
- Period_Start without a Phase_Pos fall since the previous Period_Start: treated as a missing positive sample (Sync_Err path).

Optional Feature:
- Macro DEMOD_SIGN_INV_EN.
- Defined: Err = saturate(−(acc_d >>> ACC_LOG2)), i.e. negative-half minus positive-half, matching the inverted loop polarity.
- Undefined: Err = saturate(acc_d >>> ACC_LOG2).
- Mean, timing, and flags are identical in both builds.

Test Plan:
- ACC_LOG2=2, each period one AD_VALID in each half; pos=0x9000, neg=0x7000 → after 4th closing Period_Start, Err_Valid 2 cycles later; Err=8192, Mean=0x8000.
- Same setup with pos=0xFFFF, neg=0x0000 → Err=32767 (saturated), Mean=0x7FFF; with DEMOD_SIGN_INV_EN → Err=−32768.
- Three AD_VALIDs per half, values 0x1000, 0x2000, 0x9000 (pos) and 0x7000 last (neg) → only last taken: Err=8192.
- Negative half with no AD_VALID in period 2 → Sync_Err=1, no Err_Valid for that block; next full 4 periods after resync → Err_Valid, correct Err.
- SYS_RST asserted mid-ACCUM (period 3) → outputs immediately Err=0, Mean=0x7FFF, Sync_Err=0; after release, SYNC waits for Period_Start; first Err_Valid only after 4 fresh periods.
- SYS_START dropped for 1 cycle in period 2 → IDLE, Err holds previous value, no Err_Valid until 4 full periods after next Period_Start.
